// File: rtl/lenet_window_ctrl.sv
// lenet_window_ctrl
//
// Taps the live VGA pixel stream, box-averages the centred
// (BLOCK*LENET_SIZE)^2 crop into a LENET_SIZE x LENET_SIZE 4-bit image
// buffer, launches one LeNet inference per captured frame and returns the
// classified digit to the display logic.
//
// Ports:
//   clk25         pixel clock (only clock)
//   rst           synchronous active-high reset
//   enable        allow new captures / inferences
//   frame_start   one-cycle pulse ahead of the first pixel of a frame
//   pix_valid     qualifies pix_x / pix_y / pix_data
//   pix_x, pix_y  pixel column / line
//   pix_data      4-bit grey value
//   img_raddr     LeNet read address (row*LENET_SIZE+col)
//   img_rdata     buffer read data, one cycle after img_raddr; 0 past the end
//   lenet_start   one-cycle launch pulse
//   lenet_done    one-cycle completion pulse from LeNet
//   lenet_result  class index, valid with lenet_done
//   digit         last result, 4'hF when none or invalid
//   digit_valid   one-cycle pulse whenever digit is updated
//   busy          high while capturing, launching or inferring
//   timeout_err   sticky flag: an inference was aborted on timeout
module lenet_window_ctrl #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BLOCK          = 8,
  parameter int LENET_SIZE     = 28,
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [3:0] pix_data,
  input  logic [9:0] img_raddr,
  output logic [3:0] img_rdata,
  output logic       lenet_start,
  input  logic       lenet_done,
  input  logic [3:0] lenet_result,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int WIN_L_I = H_RES / 2 - BLOCK * LENET_SIZE / 2;
  localparam int WIN_T_I = V_RES / 2 - BLOCK * LENET_SIZE / 2;
  localparam logic [9:0] WIN_L = 10'(WIN_L_I);
  localparam logic [9:0] WIN_T = 10'(WIN_T_I);
  localparam logic [9:0] WIN_R = 10'(WIN_L_I + BLOCK * LENET_SIZE - 1);
  localparam logic [9:0] WIN_B = 10'(WIN_T_I + BLOCK * LENET_SIZE - 1);

  localparam int SH     = $clog2(BLOCK);
  localparam int CW     = $clog2(LENET_SIZE);
  localparam int IMG_N  = LENET_SIZE * LENET_SIZE;
  localparam int ACC_W  = 4 + 2 * SH;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SH-1:0] PH_LAST = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    LAUNCH  = 2'd2,
    INFER   = 2'd3
  } state_t;

  // Truncating mean of one BLOCK x BLOCK block: divide by BLOCK^2.
  function automatic logic [3:0] block_mean(input logic [ACC_W-1:0] sum);
    return 4'(sum >> (2 * SH));
  endfunction

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q [LENET_SIZE];
  logic [ACC_W-1:0]  acc_d [LENET_SIZE];
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [3:0]        img_rdata_q, img_rdata_d;
  logic [3:0]        img_mem_q [IMG_N];

  logic [9:0]        dx, dy;
  logic [CW-1:0]     col_idx, row_idx;
  logic              in_win, blk_end, last_pix;
  logic [ACC_W-1:0]  acc_sum;
  logic              wr_en;
  logic [9:0]        wr_addr;
  logic [3:0]        wr_data;

  // Window decode: offsets inside the crop box and the block they fall in.
  always_comb begin
    dx       = pix_x - WIN_L;
    dy       = pix_y - WIN_T;
    in_win   = pix_valid && (pix_x >= WIN_L) && (pix_x <= WIN_R) &&
               (pix_y >= WIN_T) && (pix_y <= WIN_B);
    col_idx  = CW'(dx >> SH);
    row_idx  = CW'(dy >> SH);
    blk_end  = (dx[SH-1:0] == PH_LAST) && (dy[SH-1:0] == PH_LAST);
    last_pix = in_win && (pix_x == WIN_R) && (pix_y == WIN_B);
    acc_sum  = in_win ? (acc_q[col_idx] + ACC_W'(pix_data)) : '0;
    wr_addr  = 10'(int'(row_idx) * LENET_SIZE + int'(col_idx));
    wr_data  = block_mean(acc_sum);
  end

  // Next state, accumulators, result and timeout bookkeeping.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    timeout_err_d = timeout_err_q;
    wr_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          state_d = CAPTURE;
          acc_d   = '{default: '0};
        end
      end

      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_start) begin
          acc_d = '{default: '0};
        end else if (in_win) begin
          // One accumulator per block column serves all BLOCK lines of the
          // current block row; it is emptied as the block's last pixel lands.
          if (blk_end) begin
            wr_en            = 1'b1;
            acc_d[col_idx]   = '0;
          end else begin
            acc_d[col_idx]   = acc_sum;
          end
          if (last_pix) begin
            state_d = LAUNCH;
          end
        end
      end

      LAUNCH: begin
        cnt_d   = '0;
        state_d = INFER;
      end

      INFER: begin
        // A completion on the final allowed cycle still counts as success.
        if (lenet_done) begin
          digit_d       = lenet_result;
          digit_valid_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == T_LAST) begin
          digit_d       = 4'hF;
          digit_valid_d = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    img_rdata_d = (int'(img_raddr) < IMG_N) ? img_mem_q[img_raddr] : '0;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '{default: '0};
      cnt_q         <= '0;
      digit_q       <= 4'hF;
      digit_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      img_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      timeout_err_q <= timeout_err_d;
      img_rdata_q   <= img_rdata_d;
    end
  end

  // Image buffer storage: contents survive reset.
  always_ff @(posedge clk25) begin
    if (wr_en) begin
      img_mem_q[wr_addr] <= wr_data;
    end
  end

  assign lenet_start = (state_q == LAUNCH);
  assign busy        = (state_q != IDLE);
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign timeout_err = timeout_err_q;
  assign img_rdata   = img_rdata_q;

endmodule

// File: tb/tb_lenet_window_ctrl.sv
module tb_lenet_window_ctrl;

  localparam int T = 2500;

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [3:0] pix_data = '0;
  logic [9:0] img_raddr = '0;
  logic [3:0] img_rdata;
  logic       lenet_start;
  logic       lenet_done = 1'b0;
  logic [3:0] lenet_result = '0;
  logic [3:0] digit;
  logic       digit_valid;
  logic       busy;
  logic       timeout_err;

  lenet_window_ctrl #(
    .H_RES(640), .V_RES(480), .BLOCK(8), .LENET_SIZE(28), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk25(clk25), .rst(rst), .enable(enable), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .img_raddr(img_raddr), .img_rdata(img_rdata), .lenet_start(lenet_start),
    .lenet_done(lenet_done), .lenet_result(lenet_result), .digit(digit),
    .digit_valid(digit_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int d; int te; int lat; } dev_t;
  typedef struct { int a; int v; } rd_t;
  dev_t dq[$];
  int   sq[$];
  rd_t  rq[$];
  int   exp_mem [784];

  logic rd_en = 1'b0;
  logic rd_vld = 1'b0;
  int   last_start = 0;
  int   start_cnt = 0;

  always @(posedge clk25) rd_vld <= rd_en;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Monitor / scoreboard
  dev_t de;
  rd_t  re;
  always @(negedge clk25) begin
    if (lenet_start === 1'b1) begin
      if (sq.size() == 0) fail("unexpected_lenet_start");
      else chk("lenet_start_cycle", cyc, sq.pop_front());
      last_start = cyc;
      start_cnt++;
    end
    if (digit_valid === 1'b1) begin
      if (dq.size() == 0) fail("unexpected_digit_valid");
      else begin
        de = dq.pop_front();
        chk("digit", int'(digit), de.d);
        chk("timeout_err_at_result", int'(timeout_err), de.te);
        chk("result_latency", cyc - last_start, de.lat);
      end
    end
    if (rd_vld === 1'b1) begin
      if (rq.size() == 0) fail("unexpected_read");
      else begin
        re = rq.pop_front();
        if (int'(img_rdata) !== re.v) begin
          checks++;
          errors++;
          $display("FAIL img_rdata[%0d]: got %0d, expected %0d", re.a, img_rdata, re.v);
        end else checks++;
      end
    end
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic pix(input int x, input int y, input int d, input bit v = 1'b1);
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_data  = 4'(d);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rd(input int a, input int e);
    rd_en     = 1'b1;
    img_raddr = 10'(a);
    rq.push_back('{a, e});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_start();
    int n = start_cnt;
    for (int i = 0; i < 20 && start_cnt == n; i++) begin
      @(negedge clk25);
      #1;
    end
    if (start_cnt == n) begin
      fail("lenet_start_never_seen");
      sq.delete();
    end
    tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_digit();
    for (int i = 0; i < T + 100 && dq.size() != 0; i++) begin
      @(negedge clk25);
      #1;
    end
    if (dq.size() != 0) begin
      fail("digit_valid_never_seen");
      dq.delete();
    end
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < 784; a++) rd(a, exp_mem[a]);
    tick();
  endtask

  initial begin
    #(90000 * 40);
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v, li, s;
    // Reset values, sampled while rst is held
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    chk("rst_digit", int'(digit), 15);
    chk("rst_digit_valid", int'(digit_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lenet_start", int'(lenet_start), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_img_rdata", int'(img_rdata), 0);
    @(posedge clk25);
    #1 rst = 1'b0;
    tick();

    // Frame A: full window, each block column carries col%16
    fstart();
    for (int y = 0; y < 224; y++)
      for (int x = 0; x < 224; x++) begin
        if (x == 223 && y == 223) sq.push_back(cyc + 1);
        pix(208 + x, 128 + y, (x >> 3) % 16);
        exp_mem[(y >> 3) * 28 + (x >> 3)] = (x >> 3) % 16;
      end
    wait_start();
    chk("busy_in_infer", int'(busy), 1);
    s = last_start;
    wait_until(s + 2000);
    lenet_result = 4'd7;
    lenet_done   = 1'b1;
    dq.push_back('{7, 0, 2001});
    tick();
    lenet_done = 1'b0;
    wait_digit();
    chk("busy_after_done", int'(busy), 0);
    read_all();

    // enable low aborts a capture; frame_start without enable is ignored
    fstart();
    chk("busy_capture", int'(busy), 1);
    enable = 1'b0;
    tick();
    chk("busy_after_enable_low", int'(busy), 0);
    fstart();
    chk("busy_no_enable", int'(busy), 0);
    enable = 1'b1;

    // Frame B: sparse blocks, strays outside the window and an invalid pixel
    fstart();
    pix(431, 352, 15);
    pix(432, 351, 15);
    pix(207, 351, 15);
    pix(431, 127, 15);
    pix(431, 351, 15, 1'b0);
    for (int y = 0; y < 224; y++)
      for (int x = 0; x < 224; x++) begin
        li = (y % 8) * 8 + (x % 8);
        v = -1;
        if (x < 8 && y < 8) v = 15;
        else if ((x >> 3) == 1 && y < 8) v = (li == 0) ? 15 : 0;
        else if ((y >> 3) == 5) v = 8;
        else if ((x >> 3) == 27 && (y >> 3) == 27) v = (li < 34) ? 15 : ((li == 34) ? 1 : 0);
        if (v >= 0) begin
          if (x == 223 && y == 223) sq.push_back(cyc + 1);
          pix(208 + x, 128 + y, v);
        end
      end
    exp_mem[0] = 15;
    exp_mem[1] = 0;
    for (int c = 0; c < 28; c++) exp_mem[140 + c] = 8;
    exp_mem[783] = 7;
    wait_start();
    s = last_start;
    // New frame during INFER must neither capture nor relaunch
    fstart();
    pix(431, 351, 15);
    pix(208, 128, 15);
    // Completion on the very cycle the timeout would fire
    wait_until(s + T);
    lenet_result = 4'd3;
    lenet_done   = 1'b1;
    dq.push_back('{3, 0, T + 1});
    tick();
    lenet_done = 1'b0;
    wait_digit();
    chk("timeout_err_done_wins", int'(timeout_err), 0);
    lenet_result = 4'd9;
    lenet_done   = 1'b1;
    tick();
    lenet_done = 1'b0;
    tick();
    chk("digit_after_idle_done", int'(digit), 3);
    read_all();

    // Frame C: reset lands on pixel (300,200)
    fstart();
    for (int x = 296; x < 300; x++) pix(x, 200, 15);
    rst = 1'b1;
    pix(300, 200, 15);
    rst = 1'b0;
    chk("busy_after_rst", int'(busy), 0);
    chk("digit_after_rst", int'(digit), 15);
    lenet_result = 4'd5;
    lenet_done   = 1'b1;
    tick();
    lenet_done = 1'b0;
    tick();
    chk("digit_ignores_late_done", int'(digit), 15);

    // Frame D: clean capture, then no completion -> timeout
    fstart();
    for (int y = 0; y < 224; y++)
      for (int x = 0; x < 224; x++) begin
        li = (y % 8) * 8 + (x % 8);
        v = -1;
        if ((x >> 3) == 11 && (y >> 3) == 9) v = 4;
        else if (x < 8 && y < 8) v = (li == 0) ? 15 : 0;
        else if (x == 223 && y == 223) v = 15;
        if (v >= 0) begin
          if (x == 223 && y == 223) sq.push_back(cyc + 1);
          pix(208 + x, 128 + y, v);
        end
      end
    exp_mem[263] = 4;
    exp_mem[0]   = 0;
    exp_mem[783] = 0;
    wait_start();
    dq.push_back('{15, 1, T + 1});
    wait_digit();
    repeat (20) tick();
    chk("timeout_err_sticky", int'(timeout_err), 1);
    chk("busy_after_timeout", int'(busy), 0);
    rd(0, exp_mem[0]);
    rd(1, exp_mem[1]);
    rd(27, exp_mem[27]);
    rd(140, exp_mem[140]);
    rd(263, exp_mem[263]);
    rd(783, exp_mem[783]);
    rd(784, 0);
    rd(1023, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("timeout_err_cleared", int'(timeout_err), 0);
    chk("digit_cleared", int'(digit), 15);
    tick();
    if (sq.size() != 0 || dq.size() != 0 || rq.size() != 0) fail("scoreboard_not_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
